audio_mix_sd_dac: RTL and testbench

- Parametrised successor to the single-channel sigma-delta audio DAC used by the core top levels.
- Mixes N unsigned PCM channels with per-channel enables, for example machine audio and tape monitor.
- Saturates the sum to the DAC width and flags clipping.
- Applies a pop-free soft-mute ramp toward midscale, then drives a 1st- or 2nd-order sigma-delta 1-bit output to the AUDIO_L/R pins.

---
 rtl/audio_mix_sd_dac.sv | 149 ++++++++++++++
 tb/tb_audio_mix_sd_dac.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/audio_mix_sd_dac.sv
// N-channel PCM mixer with saturation, soft-mute ramp and 1st/2nd-order sigma-delta 1-bit DAC.
// Level path runs on the sample strobe; the modulator runs every clock.
module audio_mix_sd_dac #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned IN_BITS   = 14,
  parameter int unsigned OUT_BITS  = 15,
  parameter int unsigned ORDER     = 1,
  parameter int unsigned RAMP_STEP = 64
) (
  input  logic                        clk_i,
  input  logic                        res_n_i,
  input  logic                        ce_i,
  input  logic [CHANNELS*IN_BITS-1:0] ch_data_i,
  input  logic [CHANNELS-1:0]         ch_en_i,
  input  logic                        mute_i,
  input  logic                        clip_clr_i,
  output logic [OUT_BITS-1:0]         pcm_o,
  output logic                        dac_o,
  output logic                        muted_o,
  output logic                        clip_o
);

  localparam int unsigned SumW  = IN_BITS + $clog2(CHANNELS);
  localparam int unsigned WideW = ((SumW > OUT_BITS) ? SumW : OUT_BITS) + 1;
  localparam logic [OUT_BITS-1:0] Mid   = {1'b1, {(OUT_BITS-1){1'b0}}};
  localparam logic [OUT_BITS-1:0] FsMax = {OUT_BITS{1'b1}};
  localparam logic [OUT_BITS-1:0] Step  = OUT_BITS'(RAMP_STEP);

  typedef enum logic [1:0] {StRun, StRampDn, StMuted, StRampUp} state_e;

  state_e              state_q, state_d;
  logic [OUT_BITS-1:0] mix_q, mix_d, pcm_q, pcm_d, step_mid, step_mix;
  logic                ce_d_q, clip_q, clip_d, dac_q, dac_d, sat;
  logic [WideW-1:0]    sum;

  function automatic logic [OUT_BITS-1:0] step_toward(input logic [OUT_BITS-1:0] cur,
                                                      input logic [OUT_BITS-1:0] tgt);
    if (tgt >= cur) return ((tgt - cur) <= Step) ? tgt : cur + Step;
    else            return ((cur - tgt) <= Step) ? tgt : cur - Step;
  endfunction

  // Mixer: sum is wide enough that it never wraps before the saturation compare.
  always_comb begin
    sum = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (ch_en_i[k]) sum = sum + WideW'(ch_data_i[k*IN_BITS +: IN_BITS]);
    end
  end

  assign sat    = sum > WideW'(FsMax);
  assign mix_d  = ce_i ? (sat ? FsMax : sum[OUT_BITS-1:0]) : mix_q;
  assign clip_d = (ce_i && sat) ? 1'b1 : (clip_clr_i ? 1'b0 : clip_q);

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      mix_q   <= '0;
      ce_d_q  <= 1'b0;
      clip_q  <= 1'b0;
      state_q <= StMuted;
      pcm_q   <= Mid;
      dac_q   <= 1'b0;
    end else begin
      mix_q   <= mix_d;
      ce_d_q  <= ce_i;
      clip_q  <= clip_d;
      state_q <= state_d;
      pcm_q   <= pcm_d;
      dac_q   <= dac_d;
    end
  end

  // Entering a ramp state steps in the same cycle, except a down-ramp reversal.
  always_comb begin
    logic go_dn, go_up;
    state_d  = state_q;
    pcm_d    = pcm_q;
    go_dn    = 1'b0;
    go_up    = 1'b0;
    step_mid = step_toward(pcm_q, Mid);
    step_mix = step_toward(pcm_q, mix_q);
    if (ce_d_q) begin
      unique case (state_q)
        StRun:    if (mute_i) go_dn = 1'b1; else pcm_d = mix_q;
        StRampDn: if (mute_i) go_dn = 1'b1; else state_d = StRampUp;
        StMuted:  if (!mute_i) go_up = 1'b1;
        StRampUp: if (mute_i) go_dn = 1'b1; else go_up = 1'b1;
        default:  state_d = StMuted;
      endcase
      if (go_dn) begin
        pcm_d   = step_mid;
        state_d = (step_mid == Mid) ? StMuted : StRampDn;
      end else if (go_up) begin
        pcm_d   = step_mix;
        state_d = (step_mix == mix_q) ? StRun : StRampUp;
      end
    end
  end

  always_comb begin
    muted_o = (state_q == StMuted);
    pcm_o   = pcm_q;
    clip_o  = clip_q;
    dac_o   = dac_q;
  end

  if (ORDER == 1) begin : g_ord1
    logic [OUT_BITS-1:0] acc_q;
    logic [OUT_BITS:0]   acc_d;
    assign acc_d = {1'b0, acc_q} + {1'b0, pcm_q};
    assign dac_d = acc_d[OUT_BITS];
    always_ff @(posedge clk_i or negedge res_n_i) begin
      if (!res_n_i) acc_q <= '0;
      else          acc_q <= acc_d[OUT_BITS-1:0];
    end
  end else begin : g_ord2
    localparam int unsigned IntW = OUT_BITS + 4;
    localparam int unsigned ExtW = IntW + 2;
    localparam logic signed [ExtW-1:0] IntMax = {3'b000, {(IntW-1){1'b1}}};
    localparam logic signed [ExtW-1:0] IntMin = {3'b111, {(IntW-1){1'b0}}};
    localparam logic signed [ExtW-1:0] Fs     = {{(ExtW-OUT_BITS-1){1'b0}}, 1'b1,
                                                 {OUT_BITS{1'b0}}};
    logic signed [IntW-1:0] i1_q, i2_q, i1_d, i2_d;
    logic signed [ExtW-1:0] i1_ext, i2_ext, pcm_ext, fb, i1_sum, i2_sum;

    assign i1_ext  = {{2{i1_q[IntW-1]}}, i1_q};
    assign i2_ext  = {{2{i2_q[IntW-1]}}, i2_q};
    assign pcm_ext = {{(ExtW-OUT_BITS){1'b0}}, pcm_q};
    assign fb      = dac_q ? Fs : '0;
    assign i1_sum  = i1_ext + pcm_ext - fb;
    assign i2_sum  = i2_ext + i1_ext - fb;
    // Integrators saturate instead of wrapping so an overload cannot flip the loop sign.
    assign i1_d = (i1_sum > IntMax) ? IntMax[IntW-1:0] :
                  (i1_sum < IntMin) ? IntMin[IntW-1:0] : i1_sum[IntW-1:0];
    assign i2_d = (i2_sum > IntMax) ? IntMax[IntW-1:0] :
                  (i2_sum < IntMin) ? IntMin[IntW-1:0] : i2_sum[IntW-1:0];
    assign dac_d = ~i2_d[IntW-1];

    always_ff @(posedge clk_i or negedge res_n_i) begin
      if (!res_n_i) begin
        i1_q <= '0;
        i2_q <= '0;
      end else begin
        i1_q <= i1_d;
        i2_q <= i2_d;
      end
    end
  end

endmodule

// File: tb/tb_audio_mix_sd_dac.sv
// Directed bench for audio_mix_sd_dac: ramp, saturation, density, mute reversal, async reset.
// A second ORDER=2 instance runs concurrently for the density window.
module tb_audio_mix_sd_dac;
  localparam int unsigned Ch = 4, InB = 14, OutB = 15;

  logic clk_i = 1'b0, clk_en = 1'b1;
  logic res_n_i, ce_i, mute_i, clip_clr_i;
  logic [Ch*InB-1:0] ch_data, ch_data2;
  logic [Ch-1:0]     ch_en, ch_en2;
  logic [OutB-1:0]   pcm, pcm2;
  logic dac, dac2, muted, muted2, clip, clip2;

  int   checks = 0, failures = 0, ones = 0, ones2 = 0, win2_n = 0;
  logic win2_start = 1'b0;

  audio_mix_sd_dac #(.CHANNELS(Ch), .IN_BITS(InB), .OUT_BITS(OutB), .ORDER(1),
                     .RAMP_STEP(64)) dut (
    .clk_i(clk_i), .res_n_i(res_n_i), .ce_i(ce_i), .ch_data_i(ch_data), .ch_en_i(ch_en),
    .mute_i(mute_i), .clip_clr_i(clip_clr_i), .pcm_o(pcm), .dac_o(dac), .muted_o(muted),
    .clip_o(clip)
  );

  audio_mix_sd_dac #(.CHANNELS(Ch), .IN_BITS(InB), .OUT_BITS(OutB), .ORDER(2),
                     .RAMP_STEP(64)) dut2 (
    .clk_i(clk_i), .res_n_i(res_n_i), .ce_i(ce_i), .ch_data_i(ch_data2), .ch_en_i(ch_en2),
    .mute_i(1'b0), .clip_clr_i(1'b0), .pcm_o(pcm2), .dac_o(dac2), .muted_o(muted2),
    .clip_o(clip2)
  );

  always begin
    #5;
    if (clk_en) clk_i = ~clk_i;
  end

  // 2^16-clock ones count for the ORDER=2 instance, started from the directed sequence.
  always @(negedge clk_i) begin
    if (win2_start && win2_n < 65536) begin
      win2_n = win2_n + 1;
      if (dac2) ones2 = ones2 + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_ce(input logic clr);
    ce_i = 1'b1;
    clip_clr_i = clr;
    @(posedge clk_i);
    #1;
    ce_i = 1'b0;
    clip_clr_i = 1'b0;
    repeat (15) @(posedge clk_i);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [InB-1:0] v);
    ch_data[k*InB +: InB] = v;
  endtask

  initial begin
    res_n_i = 1'b1; ce_i = 1'b0; mute_i = 1'b0; clip_clr_i = 1'b0;
    ch_data = '0; ch_en = 4'b0001; set_ch(0, 14'h1000);
    ch_data2 = {14'h0, 14'h0, 14'h3000, 14'h3000}; ch_en2 = 4'b0011;
    #1 res_n_i = 1'b0;
    #2;
    check("rst_pcm", 32'(pcm), 32'd16384);
    check("rst_muted", 32'(muted), 32'd1);
    check("rst_clip", 32'(clip), 32'd0);
    check("rst_dac", 32'(dac), 32'd0);
    repeat (3) @(posedge clk_i);
    #1 res_n_i = 1'b1;
    check("rst_hold_pcm", 32'(pcm), 32'd16384);

    // Ramp up from MID to 4096 at 64 per ce_d.
    pulse_ce(1'b0);
    check("ramp_first", 32'(pcm), 32'd16320);
    check("ramp_unmuted", 32'(muted), 32'd0);
    repeat (190) pulse_ce(1'b0);
    check("ramp_191", 32'(pcm), 32'd4160);
    pulse_ce(1'b0);
    check("ramp_192", 32'(pcm), 32'd4096);
    check("o2_ramp_pcm", 32'(pcm2), 32'd24576);
    check("o2_muted", 32'(muted2), 32'd0);
    win2_start = 1'b1;
    set_ch(0, 14'h2000);
    pulse_ce(1'b0);
    check("run_follow", 32'(pcm), 32'd8192);

    // First-order density is exact over any 2^15-clock window.
    ones = 0;
    repeat (32768) begin
      @(posedge clk_i);
      #1;
      if (dac) ones++;
    end
    check("density_8192", 32'(ones), 32'd8192);

    // Saturation and sticky clip flag.
    ch_en = 4'b1111;
    for (int k = 0; k < 4; k++) set_ch(k, 14'h3FFF);
    pulse_ce(1'b0);
    check("sat_pcm", 32'(pcm), 32'd32767);
    check("sat_clip", 32'(clip), 32'd1);
    ch_en = 4'b0001;
    pulse_ce(1'b1);
    check("clr_clip", 32'(clip), 32'd0);
    check("clr_pcm", 32'(pcm), 32'd16383);
    ch_en = 4'b1111;
    pulse_ce(1'b1);
    check("clip_wins", 32'(clip), 32'd1);
    clip_clr_i = 1'b1;
    @(posedge clk_i);
    #1 clip_clr_i = 1'b0;
    check("clr_alone", 32'(clip), 32'd0);
    ch_en = 4'b0111;
    set_ch(2, 14'h0001);
    pulse_ce(1'b0);
    check("edge_noclip", 32'(clip), 32'd0);
    check("edge_pcm", 32'(pcm), 32'd32767);
    ch_en = 4'b1000;
    set_ch(3, 14'h0123);
    pulse_ce(1'b0);
    check("disabled_ch", 32'(pcm), 32'd291);

    // Zero level gives no ones.
    ch_en = 4'b0000;
    pulse_ce(1'b0);
    check("zero_pcm", 32'(pcm), 32'd0);
    ones = 0;
    repeat (4096) begin
      @(posedge clk_i);
      #1;
      if (dac) ones++;
    end
    check("density_0", 32'(ones), 32'd0);

    // Mute reversal: 10 steps down, one idle reversal cycle, 10 steps back.
    ch_en = 4'b0001;
    set_ch(0, 14'h1000);
    pulse_ce(1'b0);
    check("rev_start", 32'(pcm), 32'd4096);
    mute_i = 1'b1;
    repeat (10) begin
      pulse_ce(1'b0);
      check("rev_range_dn", 32'(pcm >= 15'd4096 && pcm <= 15'd4736), 32'd1);
    end
    check("rev_peak", 32'(pcm), 32'd4736);
    check("rev_not_muted", 32'(muted), 32'd0);
    mute_i = 1'b0;
    pulse_ce(1'b0);
    check("rev_no_step", 32'(pcm), 32'd4736);
    repeat (10) begin
      pulse_ce(1'b0);
      check("rev_range_up", 32'(pcm >= 15'd4096 && pcm <= 15'd4736), 32'd1);
    end
    check("rev_back", 32'(pcm), 32'd4096);
    set_ch(0, 14'h2000);
    pulse_ce(1'b0);
    check("rev_run", 32'(pcm), 32'd8192);

    // Full mute: MID reached on the 128th step.
    mute_i = 1'b1;
    repeat (127) pulse_ce(1'b0);
    check("mute_127_pcm", 32'(pcm), 32'd16320);
    check("mute_127_flag", 32'(muted), 32'd0);
    pulse_ce(1'b0);
    check("mute_128_pcm", 32'(pcm), 32'd16384);
    check("mute_128_flag", 32'(muted), 32'd1);

    // Second-order density window.
    for (int i = 0; i < 70000 && win2_n < 65536; i++) @(posedge clk_i);
    #1;
    check("o2_window_done", 32'(win2_n), 32'd65536);
    check("o2_density", 32'(ones2 >= 49087 && ones2 <= 49217), 32'd1);
    check("o2_noclip", 32'(clip2), 32'd0);

    // Async reset mid-ramp with the clock stopped.
    mute_i = 1'b0;
    ch_en = 4'b1111;
    for (int k = 0; k < 4; k++) set_ch(k, 14'h3FFF);
    repeat (5) pulse_ce(1'b0);
    check("pre_rst_pcm", 32'(pcm), 32'd16704);
    check("pre_rst_clip", 32'(clip), 32'd1);
    @(negedge clk_i);
    clk_en = 1'b0;
    #20 res_n_i = 1'b0;
    #1;
    check("arst_pcm", 32'(pcm), 32'd16384);
    check("arst_dac", 32'(dac), 32'd0);
    check("arst_muted", 32'(muted), 32'd1);
    check("arst_clip", 32'(clip), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
